// File: rtl/ram_client_adapter.sv
// ram_client_adapter: client-side master for the single-port RAM interface.
// Turns a valid/ready request stream into RAM client accesses, holds each
// access stable while the RAM stalls, and queues read data in a small
// response FIFO that is drained through a valid/ready response port.
// Optional build macro: RAM_CLIENT_WRITE_ACK_EN (writes also return a zero ack).
module ram_client_adapter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RESP_DEPTH = 4,
    localparam int BYTE_COUNT = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_we,
    input  logic [BYTE_COUNT-1:0] req_be,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  ram_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data_w,
    output logic                  ram_we,
    output logic [BYTE_COUNT-1:0] ram_be,
    input  logic [DATA_WIDTH-1:0] ram_data_r,
    input  logic                  ram_delay,
    output logic                  busy
);

    localparam int PW = $clog2(RESP_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(RESP_DEPTH);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic [BYTE_COUNT-1:0] be_q, be_d;
    logic                  pend_q, pend_d;

    logic [DATA_WIDTH-1:0] mem_q [RESP_DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic                  fire, accept, push, pop, issuing;
    logic [1:0]            inflight;
    logic [DATA_WIDTH-1:0] push_data;

    assign issuing = (state_q == ISSUE);
    assign accept  = issuing && !ram_delay;
    assign push    = pend_q;
    assign pop     = resp_valid && resp_ready;

`ifdef RAM_CLIENT_WRITE_ACK_EN
    logic pend_rd_q;
    // Every accepted access leaves a capture slot; remember whether it was a read.
    always_ff @(posedge clk) begin
        if (reset) pend_rd_q <= 1'b0;
        else       pend_rd_q <= accept && !we_q;
    end
    assign pend_d    = accept;
    assign inflight  = {1'b0, issuing} + {1'b0, pend_q};
    assign push_data = pend_rd_q ? ram_data_r : '0;
`else
    assign pend_d    = accept && !we_q;
    assign inflight  = {1'b0, issuing && !we_q} + {1'b0, pend_q};
    assign push_data = ram_data_r;
`endif

    // Credit covers queued entries plus reads not yet captured; a same-cycle
    // pop is deliberately ignored so resp_ready never reaches req_ready.
    assign req_ready = !reset && (!issuing || !ram_delay) &&
                       (({1'b0, cnt_q} + {{(CW-1){1'b0}}, inflight}) < DEPTH_C);
    assign fire      = req_valid && req_ready;

    assign ram_en     = issuing;
    assign ram_addr   = addr_q;
    assign ram_data_w = wdata_q;
    assign ram_we     = we_q;
    assign ram_be     = be_q;
    assign resp_valid = (cnt_q != '0);
    assign resp_rdata = mem_q[rd_ptr_q];
    assign busy       = issuing || pend_q || resp_valid;

    // Next state and access registers: load on fire, hold while stalled.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        be_d    = be_q;
        case (state_q)
            IDLE: begin
                if (fire) state_d = ISSUE;
            end
            ISSUE: begin
                if (!ram_delay && !fire) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (fire) begin
            addr_d  = req_addr;
            wdata_d = req_wdata;
            we_d    = req_we;
            be_d    = req_be;
        end
    end

    // FSM state, RAM-facing access registers and the capture-pending flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            be_q    <= be_d;
            pend_q  <= pend_d;
        end
    end

    // Occupancy: simultaneous push and pop leave it unchanged.
    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + CW'(1);
        else if (!push && pop) cnt_d = cnt_q - CW'(1);
    end

    // Response FIFO storage and pointers; reset clears the entries so the head reads zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RESP_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            cnt_q <= cnt_d;
        end
    end

    // Credit accounting must make a push into a full FIFO impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && (cnt_q == CW'(RESP_DEPTH))));

endmodule

// File: tb/tb_ram_client_adapter.sv
// Directed testbench for ram_client_adapter with a behavioural RAM that
// returns (addr ^ 0xA5A50000) on reads, except 0xDEADBEEF at address 0x100.
module tb_ram_client_adapter;

    logic        clk;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_rdata;
    logic        ram_en, ram_we, ram_delay, busy;
    logic [31:0] ram_addr, ram_data_w, ram_data_r;
    logic [3:0]  ram_be;

    int vectors = 0;
    int errors  = 0;

    ram_client_adapter dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_be(req_be), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .ram_en(ram_en), .ram_addr(ram_addr), .ram_data_w(ram_data_w),
        .ram_we(ram_we), .ram_be(ram_be), .ram_data_r(ram_data_r),
        .ram_delay(ram_delay), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: read data appears one cycle after an accepted read.
    always @(posedge clk) begin
        if (ram_en && !ram_delay && !ram_we)
            ram_data_r <= (ram_addr == 32'h100) ? 32'hDEADBEEF : (ram_addr ^ 32'hA5A50000);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        #1;
        vectors++; if (ram_en !== 1'b0) begin errors++; $display("FAIL rst_ram_en: got %0h want 0", ram_en); end
        vectors++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %0h want 0", resp_valid); end
        vectors++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %0h want 0", req_ready); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0h want 0", busy); end
        vectors++; if (ram_addr !== 32'h0) begin errors++; $display("FAIL rst_ram_addr: got %h want 0", ram_addr); end
        vectors++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", resp_rdata); end
        reset = 1'b0;
        #1;
        vectors++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %0h want 1", req_ready); end
    endtask

    task automatic test_single_read();
        tick();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100;
        #1;
        vectors++; if (req_ready !== 1'b1) begin errors++; $display("FAIL sr_ready: got %0h want 1", req_ready); end
        tick();  // c1
        req_valid = 1'b0;
        #1;
        vectors++; if (ram_en !== 1'b1) begin errors++; $display("FAIL sr_c1_en: got %0h want 1", ram_en); end
        vectors++; if (ram_addr !== 32'h100) begin errors++; $display("FAIL sr_c1_addr: got %h want 00000100", ram_addr); end
        vectors++; if (ram_we !== 1'b0) begin errors++; $display("FAIL sr_c1_we: got %0h want 0", ram_we); end
        tick();  // c2
        vectors++; if (ram_en !== 1'b0) begin errors++; $display("FAIL sr_c2_en: got %0h want 0", ram_en); end
        vectors++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL sr_c2_valid: got %0h want 0", resp_valid); end
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL sr_c2_busy: got %0h want 1", busy); end
        tick();  // c3
        vectors++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL sr_c3_valid: got %0h want 1", resp_valid); end
        vectors++; if (resp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sr_c3_rdata: got %h want deadbeef", resp_rdata); end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        #1;
        vectors++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL sr_pop_valid: got %0h want 0", resp_valid); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL sr_pop_busy: got %0h want 0", busy); end
    endtask

    task automatic test_stall();
        tick();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h200;
        #1;
        vectors++; if (req_ready !== 1'b1) begin errors++; $display("FAIL st_ready: got %0h want 1", req_ready); end
        tick();  // c1
        req_valid = 1'b0; ram_delay = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            vectors++; if (ram_en !== 1'b1) begin errors++; $display("FAIL st_hold_en[%0d]: got %0h want 1", i, ram_en); end
            vectors++; if (ram_addr !== 32'h200) begin errors++; $display("FAIL st_hold_addr[%0d]: got %h want 00000200", i, ram_addr); end
            vectors++; if (req_ready !== 1'b0) begin errors++; $display("FAIL st_hold_ready[%0d]: got %0h want 0", i, req_ready); end
            tick();
            if (i == 2) ram_delay = 1'b0;
            #1;
        end
        // c4: stall released, access still presented
        vectors++; if (ram_en !== 1'b1) begin errors++; $display("FAIL st_c4_en: got %0h want 1", ram_en); end
        vectors++; if (ram_addr !== 32'h200) begin errors++; $display("FAIL st_c4_addr: got %h want 00000200", ram_addr); end
        vectors++; if (req_ready !== 1'b1) begin errors++; $display("FAIL st_c4_ready: got %0h want 1", req_ready); end
        tick();  // c5
        vectors++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL st_c5_valid: got %0h want 0", resp_valid); end
        tick();  // c6
        vectors++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL st_c6_valid: got %0h want 1", resp_valid); end
        vectors++; if (resp_rdata !== 32'hA5A50200) begin errors++; $display("FAIL st_c6_rdata: got %h want a5a50200", resp_rdata); end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        #1;
    endtask

    task automatic test_back_to_back();
        tick();
        resp_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k < 8) begin
                req_valid = 1'b1; req_we = 1'b0; req_addr = 32'(k * 4);
            end else begin
                req_valid = 1'b0;
            end
            #1;
            if (k < 8) begin
                vectors++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %0h want 1", k, req_ready); end
            end
            if (k >= 1 && k <= 8) begin
                vectors++; if (ram_en !== 1'b1) begin errors++; $display("FAIL b2b_en[%0d]: got %0h want 1", k, ram_en); end
                vectors++; if (ram_addr !== 32'((k - 1) * 4)) begin errors++; $display("FAIL b2b_addr[%0d]: got %h want %h", k, ram_addr, 32'((k - 1) * 4)); end
            end else begin
                vectors++; if (ram_en !== 1'b0) begin errors++; $display("FAIL b2b_en[%0d]: got %0h want 0", k, ram_en); end
            end
            if (k >= 3 && k <= 10) begin
                vectors++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %0h want 1", k, resp_valid); end
                vectors++; if (resp_rdata !== (32'hA5A50000 | 32'((k - 3) * 4))) begin errors++; $display("FAIL b2b_rdata[%0d]: got %h want %h", k, resp_rdata, 32'hA5A50000 | 32'((k - 3) * 4)); end
            end else begin
                vectors++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid[%0d]: got %0h want 0", k, resp_valid); end
            end
            tick();
        end
        resp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int fires;
        logic [31:0] a;
        fires = 0;
        a = 32'h300;
        tick();
        resp_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = a;
            #1;
            if (req_ready) begin
                fires++;
                a = a + 32'h4;
            end
            tick();
        end
        req_valid = 1'b0;
        #1;
        vectors++; if (fires !== 4) begin errors++; $display("FAIL bp_accepted: got %0d want 4", fires); end
        vectors++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %0h want 0", req_ready); end
        vectors++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %0h want 1", resp_valid); end
        vectors++; if (resp_rdata !== 32'hA5A50300) begin errors++; $display("FAIL bp_head: got %h want a5a50300", resp_rdata); end
        resp_ready = 1'b1;
        #1;
        vectors++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_pop_same_cycle_ready: got %0h want 0", req_ready); end
        tick();
        resp_ready = 1'b0;
        #1;
        vectors++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_pop_next_ready: got %0h want 1", req_ready); end
        for (int i = 1; i < 4; i++) begin
            vectors++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL bp_drain_valid[%0d]: got %0h want 1", i, resp_valid); end
            vectors++; if (resp_rdata !== (32'hA5A50300 | 32'(i * 4))) begin errors++; $display("FAIL bp_drain_rdata[%0d]: got %h want %h", i, resp_rdata, 32'hA5A50300 | 32'(i * 4)); end
            resp_ready = 1'b1;
            tick();
            resp_ready = 1'b0;
            #1;
        end
        vectors++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %0h want 0", resp_valid); end
    endtask

    task automatic test_write();
        tick();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_be = 4'b0011; req_wdata = 32'hCAFEF00D;
        #1;
        vectors++; if (req_ready !== 1'b1) begin errors++; $display("FAIL wr_ready: got %0h want 1", req_ready); end
        tick();  // c1
        req_valid = 1'b0; req_we = 1'b0; req_be = 4'b0000; req_wdata = 32'h0;
        #1;
        vectors++; if (ram_en !== 1'b1) begin errors++; $display("FAIL wr_en: got %0h want 1", ram_en); end
        vectors++; if (ram_we !== 1'b1) begin errors++; $display("FAIL wr_we: got %0h want 1", ram_we); end
        vectors++; if (ram_be !== 4'b0011) begin errors++; $display("FAIL wr_be: got %b want 0011", ram_be); end
        vectors++; if (ram_data_w !== 32'hCAFEF00D) begin errors++; $display("FAIL wr_data: got %h want cafef00d", ram_data_w); end
        vectors++; if (ram_addr !== 32'h40) begin errors++; $display("FAIL wr_addr: got %h want 00000040", ram_addr); end
        tick();  // c2
        vectors++; if (ram_en !== 1'b0) begin errors++; $display("FAIL wr_c2_en: got %0h want 0", ram_en); end
        tick();  // c3
`ifdef RAM_CLIENT_WRITE_ACK_EN
        vectors++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL wr_ack_valid: got %0h want 1", resp_valid); end
        vectors++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL wr_ack_rdata: got %h want 0", resp_rdata); end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        #1;
        vectors++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL wr_ack_popped: got %0h want 0", resp_valid); end
`else
        vectors++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL wr_no_resp: got %0h want 0", resp_valid); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy: got %0h want 0", busy); end
`endif
    endtask

    task automatic test_reset_mid();
        tick();
        resp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h500;
        #1;
        tick();  // c1
        req_addr = 32'h504;
        #1;
        tick();  // c2
        req_valid = 1'b0;
        #1;
        tick();  // c3
        tick();  // c4: two responses queued
        vectors++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL rm_queued_valid: got %0h want 1", resp_valid); end
        vectors++; if (resp_rdata !== 32'hA5A50500) begin errors++; $display("FAIL rm_queued_head: got %h want a5a50500", resp_rdata); end
        req_valid = 1'b1; req_addr = 32'h508;
        #1;
        vectors++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rm_c4_ready: got %0h want 1", req_ready); end
        tick();  // c5: issue of 0x508, stalled
        req_valid = 1'b0; ram_delay = 1'b1;
        #1;
        vectors++; if (ram_en !== 1'b1) begin errors++; $display("FAIL rm_c5_en: got %0h want 1", ram_en); end
        reset = 1'b1;
        #1;
        vectors++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rm_reset_ready: got %0h want 0", req_ready); end
        tick();  // c6
        reset = 1'b0; ram_delay = 1'b0;
        #1;
        vectors++; if (ram_en !== 1'b0) begin errors++; $display("FAIL rm_c6_en: got %0h want 0", ram_en); end
        vectors++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rm_c6_valid: got %0h want 0", resp_valid); end
        vectors++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL rm_c6_rdata: got %h want 0", resp_rdata); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_c6_busy: got %0h want 0", busy); end
        vectors++; if (ram_addr !== 32'h0) begin errors++; $display("FAIL rm_c6_addr: got %h want 0", ram_addr); end
        vectors++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rm_c6_ready: got %0h want 1", req_ready); end
        req_valid = 1'b1; req_addr = 32'h600;
        #1;
        tick();  // c7
        req_valid = 1'b0;
        #1;
        vectors++; if (ram_en !== 1'b1) begin errors++; $display("FAIL rm_post_en: got %0h want 1", ram_en); end
        vectors++; if (ram_addr !== 32'h600) begin errors++; $display("FAIL rm_post_addr: got %h want 00000600", ram_addr); end
        tick();  // c8
        tick();  // c9
        vectors++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL rm_post_valid: got %0h want 1", resp_valid); end
        vectors++; if (resp_rdata !== 32'hA5A50600) begin errors++; $display("FAIL rm_post_rdata: got %h want a5a50600", resp_rdata); end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        #1;
        vectors++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rm_post_popped: got %0h want 0", resp_valid); end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_be = '0;
        req_wdata = '0; resp_ready = 1'b0; ram_delay = 1'b0; ram_data_r = '0;
        test_reset();
        test_single_read();
        test_stall();
        test_back_to_back();
        test_backpressure();
        test_write();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
